// File: rtl/i3c_pkg.sv
// Shared definitions for the I3C SDR broadcast CCC transmitter: state encoding,
// broadcast address constants and the T-bit parity helper.
package i3c_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_ADDR  = 3'd2,
    S_ACK   = 3'd3,
    S_CMD   = 3'd4,
    S_TBIT  = 3'd5,
    S_STOP  = 3'd6
  } state_t;

  localparam logic [6:0] BCAST_ADDR = 7'h7E;
  localparam logic       RNW_WRITE  = 1'b0;
  localparam logic [7:0] ADDR_BYTE  = {BCAST_ADDR, RNW_WRITE};

  // T-bit: set when the byte holds an even number of ones (odd parity overall).
  function automatic logic odd_parity(input logic [7:0] data);
    return ~^data;
  endfunction

endpackage

// File: rtl/i3c_scl_phase.sv
// SCL half-period timer: counts SCL_DIV cycles per half-period while run is high
// and tracks whether the current half-period is the SCL-high one.
module i3c_scl_phase #(
  parameter int SCL_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  output logic phase_first,
  output logic phase_last,
  output logic phase_high
);

  localparam logic [7:0] LAST = 8'(SCL_DIV - 1);

  logic [7:0] cnt;
  logic       high;

  // A transfer opens with the START half-period, during which SCL is high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt  <= '0;
      high <= 1'b1;
    end else if (!run) begin
      cnt  <= '0;
      high <= 1'b1;
    end else if (cnt == LAST) begin
      cnt  <= '0;
      high <= ~high;
    end else begin
      cnt <= cnt + 8'd1;
    end
  end

  assign phase_first = run && (cnt == 8'd0);
  assign phase_last  = run && (cnt == LAST);
  assign phase_high  = high;

endmodule

// File: rtl/i3c_sdr_broadcast_tx.sv
// Controller-side I3C SDR broadcast CCC transmitter: START, 7'h7E+W, ACK,
// CCC byte, T-bit, STOP. All pad-facing outputs are registered.
module i3c_sdr_broadcast_tx
  import i3c_pkg::*;
#(
  parameter int SCL_DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] ccc_code,
  input  logic       sda_i,
  output logic       scl_o,
  output logic       sda_o,
  output logic       sda_oe,
  output logic       busy,
  output logic       done,
  output logic       nack
);

  state_t     state;
  logic [3:0] bit_cnt;
  logic [7:0] shift;
  logic       tbit;
  logic       nack_flag;
  logic       phase_first;
  logic       phase_last;
  logic       phase_high;
  logic [2:0] addr_idx;

  i3c_scl_phase #(.SCL_DIV(SCL_DIV)) u_phase (
    .clk         (clk),
    .rst         (rst),
    .run         (busy),
    .phase_first (phase_first),
    .phase_last  (phase_last),
    .phase_high  (phase_high)
  );

  // Address bit driven in the slot following the current one.
  assign addr_idx = 3'd6 - bit_cnt[2:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      bit_cnt   <= '0;
      shift     <= '0;
      tbit      <= 1'b0;
      nack_flag <= 1'b0;
      scl_o     <= 1'b1;
      sda_o     <= 1'b1;
      sda_oe    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      nack      <= 1'b0;
    end else begin
      done <= 1'b0;
      nack <= 1'b0;
      case (state)
        S_IDLE: begin
          // done=1 marks the cycle right after a transfer; requests there are dropped.
          if (start && !busy && !done) begin
            state     <= S_START;
            bit_cnt   <= '0;
            shift     <= ccc_code;
            tbit      <= odd_parity(ccc_code);
            nack_flag <= 1'b0;
            busy      <= 1'b1;
            scl_o     <= 1'b1;
            sda_oe    <= 1'b1;
            sda_o     <= 1'b0;
          end
        end
        S_START: if (phase_last) begin
          state   <= S_ADDR;
          bit_cnt <= '0;
          scl_o   <= 1'b0;
          sda_o   <= ADDR_BYTE[7];
          sda_oe  <= ~ADDR_BYTE[7];
        end
        S_ADDR: if (phase_last) begin
          if (!phase_high) begin
            scl_o <= 1'b1;
          end else if (bit_cnt == 4'd7) begin
            state   <= S_ACK;
            bit_cnt <= '0;
            scl_o   <= 1'b0;
            sda_o   <= 1'b1;
            sda_oe  <= 1'b0;
          end else begin
            bit_cnt <= bit_cnt + 4'd1;
            scl_o   <= 1'b0;
            sda_o   <= ADDR_BYTE[addr_idx];
            sda_oe  <= ~ADDR_BYTE[addr_idx];
          end
        end
        S_ACK: begin
          if (phase_first && phase_high) nack_flag <= sda_i;
          if (phase_last) begin
            if (!phase_high) begin
              scl_o <= 1'b1;
            end else begin
              bit_cnt <= '0;
              scl_o   <= 1'b0;
              sda_oe  <= 1'b1;
              if (nack_flag) begin
                state <= S_STOP;
                sda_o <= 1'b0;
              end else begin
                state <= S_CMD;
                sda_o <= shift[7];
                shift <= {shift[6:0], 1'b0};
              end
            end
          end
        end
        S_CMD: if (phase_last) begin
          if (!phase_high) begin
            scl_o <= 1'b1;
          end else if (bit_cnt == 4'd7) begin
            state   <= S_TBIT;
            bit_cnt <= '0;
            scl_o   <= 1'b0;
            sda_o   <= tbit;
          end else begin
            bit_cnt <= bit_cnt + 4'd1;
            scl_o   <= 1'b0;
            sda_o   <= shift[7];
            shift   <= {shift[6:0], 1'b0};
          end
        end
        S_TBIT: if (phase_last) begin
          if (!phase_high) begin
            scl_o <= 1'b1;
          end else begin
            state   <= S_STOP;
            bit_cnt <= '0;
            scl_o   <= 1'b0;
            sda_o   <= 1'b0;
            sda_oe  <= 1'b1;
          end
        end
        S_STOP: if (phase_last) begin
          // Three half-periods: SCL low, SCL high with SDA low, SDA released.
          if (bit_cnt == 4'd0) begin
            bit_cnt <= 4'd1;
            scl_o   <= 1'b1;
          end else if (bit_cnt == 4'd1) begin
            bit_cnt <= 4'd2;
            sda_o   <= 1'b1;
            sda_oe  <= 1'b0;
          end else begin
            state   <= S_IDLE;
            bit_cnt <= '0;
            busy    <= 1'b0;
            done    <= 1'b1;
            nack    <= nack_flag;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/i3c_sdr_broadcast_tx.md
# i3c_sdr_broadcast_tx

Controller-side transmitter for I3C SDR broadcast Common Command Codes (CCC). On request, generates the full bus sequence on SCL/SDA: START, broadcast address 7'h7E + W, ACK sample, CCC byte, T-bit and STOP. It is the initiator counterpart of the target-side broadcast receiver, and it sits between the APB register block and the SCL/SDA pad cells.

## Interface
- SCL_DIV, default 4: clk cycles per SCL half-period; legal range 2..255.
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request; accepted only when busy=0, ignored otherwise.
- ccc_code  in  8  CCC byte; latched in the cycle start is accepted.
- sda_i  in  1  synchronized SDA input from the pad, used for the ACK sample.
- scl_o  out  1  SCL drive level (controller always drives SCL).
- sda_o  out  1  SDA drive level, valid when sda_oe=1.
- sda_oe  out  1  SDA output enable; 0 = released (pull-up high).
- busy  out  1  high from the cycle after acceptance until return to IDLE.
- done  out  1  one-cycle pulse on return to IDLE.
- nack  out  1  one-cycle pulse coincident with done when the address was NACKed.

## Operation
- Reset values: scl_o=1, sda_o=1, sda_oe=0, busy=0, done=0, nack=0, state IDLE. Reset mid-transfer releases SDA and drives SCL high immediately. No STOP is generated.
- Bit slot = LOW phase (scl_o=0, SCL_DIV cycles) followed by HIGH phase (scl_o=1, SCL_DIV cycles). SDA updates only in the first cycle of the LOW phase.
- States and transitions:
  - IDLE: bus released, SCL high. start → START.
  - START: sda_oe=1, sda_o=0, scl_o=1 for SCL_DIV cycles → ADDR.
  - ADDR: 8 slots sending 8'hFC (7'h7E, then R/W=0), MSB first. Open-drain: a 0 bit gives sda_oe=1, sda_o=0; a 1 bit gives sda_oe=0. After the 8th slot → ACK.
  - ACK: sda_oe=0. sda_i is sampled in the first HIGH-phase cycle. 0 → CMD; 1 → STOP with the NACK flag set.
  - CMD: 8 slots sending the latched ccc_code MSB first, push-pull (sda_oe=1) → TBIT.
  - TBIT: 1 slot, push-pull, value = odd parity = ~^ccc_code → STOP.
  - STOP: LOW phase with sda_oe=1, sda_o=0 (SCL_DIV cycles); SCL high with SDA low (SCL_DIV cycles); SDA released high with SCL high (SCL_DIV cycles) → IDLE.
- Bit counter is 4 bits and is cleared on every state entry. ccc_code is held in a shift register and is not re-read during the transfer.
- start asserted in the same cycle as done is ignored. A new request needs busy=0 in the request cycle.

## Timing
- Acceptance cycle = cycle 0. busy=1 and START begins at cycle 1. First SCL fall is at cycle 1+SCL_DIV.
- ACKed transfer: START D + ADDR 16D + ACK 2D + CMD 16D + TBIT 2D + STOP 3D = 40·D cycles, where D=SCL_DIV. done pulses at cycle 40·D+1, and busy is 0 in that same cycle.
- NACKed transfer: 22·D cycles total. done and nack pulse together at cycle 22·D+1.
- SDA never changes while scl_o=1, except at the START falling edge and the STOP rising edge.

## Structure
- Shared package i3c_pkg holds:
  - the state encoding, 3-bit: IDLE, START, ADDR, ACK, CMD, TBIT, STOP;
  - the BCAST_ADDR=7'h7E constant;
  - the RNW_WRITE=1'b0 constant;
  - an odd_parity(8-bit) function.
- One sub-module, i3c_scl_phase: a half-period counter with SCL_DIV as a parameter. It emits phase_first (first cycle of each half-period), phase_last and a high/low phase flag. The FSM advances only on phase_last.

## Test plan
- SCL_DIV=4, ccc_code=8'h06, target ACKs (sda_i=0 during ACK) → 8'hFC then 8'h06 on SDA, T-bit=1. done pulses at cycle 161 and nack stays 0.
- ccc_code=8'h07 → T-bit=0. ccc_code=8'h00 → T-bit=1 (odd parity check).
- sda_i held 1 during ACK → no CMD slots; STOP follows the ACK slot. done and nack both pulse at cycle 89 (SCL_DIV=4).
- start re-pulsed at cycles 5 and 100 of an active transfer → ignored. ccc_code changed mid-transfer → transmitted byte unchanged.
- rst asserted during the CMD phase → next cycle shows scl_o=1, sda_oe=0, busy=0. A fresh start afterwards completes normally.
- SCL_DIV=2, back-to-back requests with start issued the cycle after done → second transfer starts cleanly. The protocol monitor shows no SDA change while SCL is high except at START/STOP.
